// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB for one instruction at a time,
// decodes opcode/funct into datapath enables and selects, stalls on the
// data-memory ready handshake, and keeps retired-instruction and cycle
// counters.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             dm_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             grf_we,
    output logic             dm_we,
    output logic             dm_req,
    output logic [1:0]       npc_sel,
    output logic [2:0]       alu_op,
    output logic             alu_b_sel,
    output logic             ext_op,
    output logic [1:0]       a3_sel,
    output logic [1:0]       wd_sel,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t            state_r;
    state_t            next_s;
    logic [CNT_W-1:0]  instr_cnt_r;
    logic [CNT_W-1:0]  cycle_cnt_r;

    logic              pc_we_s;
    logic              ir_we_s;
    logic              grf_we_s;
    logic              dm_we_s;
    logic              dm_req_s;
    logic              illegal_s;
    logic              retire_s;
    logic [1:0]        npc_sel_s;
    logic [2:0]        alu_op_s;
    logic              alu_b_sel_s;
    logic              ext_op_s;
    logic [1:0]        a3_sel_s;
    logic [1:0]        wd_sel_s;

    // Instruction class decode; IR is stable from DECODE until retirement.
    logic is_rtype_s, is_addu_s, is_subu_s, is_jr_s;
    logic is_ori_s, is_lui_s, is_lw_s, is_sw_s, is_beq_s, is_j_s, is_jal_s;
    logic known_op_s, is_illegal_s;

    assign is_rtype_s   = (opcode == OP_RTYPE);
    assign is_addu_s    = is_rtype_s && (funct == FN_ADDU);
    assign is_subu_s    = is_rtype_s && (funct == FN_SUBU);
    assign is_jr_s      = is_rtype_s && (funct == FN_JR);
    assign is_ori_s     = (opcode == OP_ORI);
    assign is_lui_s     = (opcode == OP_LUI);
    assign is_lw_s      = (opcode == OP_LW);
    assign is_sw_s      = (opcode == OP_SW);
    assign is_beq_s     = (opcode == OP_BEQ);
    assign is_j_s       = (opcode == OP_J);
    assign is_jal_s     = (opcode == OP_JAL);
    assign known_op_s   = is_rtype_s || is_ori_s || is_lui_s || is_lw_s ||
                          is_sw_s || is_beq_s || is_j_s || is_jal_s;
    assign is_illegal_s = !known_op_s ||
                          (is_rtype_s && !(is_addu_s || is_subu_s || is_jr_s));

    // Next-state and datapath control decode from current state and IR fields.
    always_comb begin
        next_s      = S_FETCH;
        pc_we_s     = 1'b0;
        ir_we_s     = 1'b0;
        grf_we_s    = 1'b0;
        dm_we_s     = 1'b0;
        dm_req_s    = 1'b0;
        illegal_s   = 1'b0;
        retire_s    = 1'b0;
        npc_sel_s   = 2'd0;
        alu_op_s    = 3'd0;
        alu_b_sel_s = 1'b0;
        ext_op_s    = 1'b0;
        a3_sel_s    = 2'd0;
        wd_sel_s    = 2'd0;
        case (state_r)
            S_FETCH: begin
                ir_we_s   = 1'b1;
                pc_we_s   = 1'b1;
                npc_sel_s = 2'd0;
                next_s    = S_DECODE;
            end
            S_DECODE: begin
                if (is_j_s) begin
                    pc_we_s   = 1'b1;
                    npc_sel_s = 2'd2;
                    retire_s  = 1'b1;
                    next_s    = S_FETCH;
                end else if (is_jal_s) begin
                    pc_we_s   = 1'b1;
                    npc_sel_s = 2'd2;
                    grf_we_s  = 1'b1;
                    a3_sel_s  = 2'd2;
                    wd_sel_s  = 2'd2;
                    retire_s  = 1'b1;
                    next_s    = S_FETCH;
                end else if (is_jr_s) begin
                    pc_we_s   = 1'b1;
                    npc_sel_s = 2'd3;
                    retire_s  = 1'b1;
                    next_s    = S_FETCH;
                end else if (is_illegal_s) begin
                    // Unknown encodings retire as a nop; PC already advanced in FETCH.
                    illegal_s = 1'b1;
                    retire_s  = 1'b1;
                    next_s    = S_FETCH;
                end else begin
                    next_s    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_addu_s) begin
                    alu_op_s = 3'd0;
                    next_s   = S_WB;
                end else if (is_subu_s) begin
                    alu_op_s = 3'd1;
                    next_s   = S_WB;
                end else if (is_ori_s) begin
                    alu_op_s    = 3'd2;
                    alu_b_sel_s = 1'b1;
                    ext_op_s    = 1'b0;
                    next_s      = S_WB;
                end else if (is_lui_s) begin
                    alu_op_s    = 3'd3;
                    alu_b_sel_s = 1'b1;
                    next_s      = S_WB;
                end else if (is_lw_s || is_sw_s) begin
                    alu_op_s    = 3'd0;
                    alu_b_sel_s = 1'b1;
                    ext_op_s    = 1'b1;
                    next_s      = S_MEM;
                end else if (is_beq_s) begin
                    alu_op_s = 3'd1;
                    ext_op_s = 1'b1;
                    if (zero) begin
                        pc_we_s   = 1'b1;
                        npc_sel_s = 2'd1;
                    end else begin
                        pc_we_s   = 1'b0;
                        npc_sel_s = 2'd0;
                    end
                    retire_s = 1'b1;
                    next_s   = S_FETCH;
                end else begin
                    // Unreachable with a stable IR; recover to FETCH.
                    next_s = S_FETCH;
                end
            end
            S_MEM: begin
                dm_req_s = 1'b1;
                dm_we_s  = is_sw_s;
                if (!dm_ready) begin
                    next_s = S_MEM;
                end else if (is_sw_s) begin
                    retire_s = 1'b1;
                    next_s   = S_FETCH;
                end else if (is_lw_s) begin
                    next_s = S_WB;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_WB: begin
                grf_we_s = 1'b1;
                a3_sel_s = is_rtype_s ? 2'd1 : 2'd0;
                wd_sel_s = is_lw_s ? 2'd1 : 2'd0;
                retire_s = 1'b1;
                next_s   = S_FETCH;
            end
            default: begin
                next_s = S_FETCH;
            end
        endcase
    end

    // State register and counters; reset aborts any in-flight instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_FETCH;
            instr_cnt_r <= {CNT_W{1'b0}};
            cycle_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= next_s;
            cycle_cnt_r <= cycle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (retire_s) begin
                instr_cnt_r <= instr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Enables are forced low while reset is held, whatever the state.
    assign pc_we     = reset & pc_we_s;
    assign ir_we     = reset & ir_we_s;
    assign grf_we    = reset & grf_we_s;
    assign dm_we     = reset & dm_we_s;
    assign dm_req    = reset & dm_req_s;
    assign illegal   = reset & illegal_s;
    assign npc_sel   = npc_sel_s;
    assign alu_op    = alu_op_s;
    assign alu_b_sel = alu_b_sel_s;
    assign ext_op    = ext_op_s;
    assign a3_sel    = a3_sel_s;
    assign wd_sel    = wd_sel_s;
    assign state     = state_r;
    assign instr_cnt = instr_cnt_r;
    assign cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: per-cycle expected control vectors
// and counter values are written out by hand for each instruction.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        dm_ready = 1'b1;
    logic        pc_we, ir_we, grf_we, dm_we, dm_req, alu_b_sel, ext_op, illegal;
    logic [1:0]  npc_sel, a3_sel, wd_sel;
    logic [2:0]  alu_op, state;
    logic [31:0] instr_cnt, cycle_cnt;

    int checks = 0;
    int errors = 0;
    int exp_ic = 0;
    int exp_cc = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .dm_ready(dm_ready), .pc_we(pc_we), .ir_we(ir_we), .grf_we(grf_we),
        .dm_we(dm_we), .dm_req(dm_req), .npc_sel(npc_sel), .alu_op(alu_op),
        .alu_b_sel(alu_b_sel), .ext_op(ext_op), .a3_sel(a3_sel), .wd_sel(wd_sel),
        .state(state), .illegal(illegal), .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
    );

    logic [19:0] outs;
    assign outs = {state, pc_we, ir_we, grf_we, dm_we, dm_req, npc_sel, alu_op,
                   alu_b_sel, ext_op, a3_sel, wd_sel, illegal};

    // Packs an expected control vector in the same order as outs.
    function automatic logic [19:0] ev(input logic [2:0] st, input logic pc, input logic ir,
        input logic grf, input logic dwe, input logic dreq, input logic [1:0] npc,
        input logic [2:0] alu, input logic bsel, input logic ext, input logic [1:0] a3,
        input logic [1:0] wd, input logic ill);
        return {st, pc, ir, grf, dwe, dreq, npc, alu, bsel, ext, a3, wd, ill};
    endfunction

    logic [19:0] fetch_v;
    assign fetch_v = {3'd0, 1'b1, 1'b1, 15'd0};

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (outs !== 20'd0) begin
            errors++; $display("FAIL reset_outs got %h exp %h", outs, 20'd0);
        end
        checks++;
        if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", instr_cnt, cycle_cnt);
        end
        reset = 1'b1;
        exp_ic = 0; exp_cc = 0;
    endtask

    task automatic test_addu();
        logic [19:0] e [4];
        e[0] = fetch_v;
        e[1] = ev(3'd1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 2'd0, 2'd0, 0);
        e[2] = ev(3'd2, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 2'd0, 2'd0, 0);
        e[3] = ev(3'd4, 0, 0, 1, 0, 0, 2'd0, 3'd0, 0, 0, 2'd1, 2'd0, 0);
        opcode = 6'b000000; funct = 6'b100001; dm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs !== e[i]) begin
                errors++; $display("FAIL addu_c%0d got %h exp %h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
        exp_ic += 1; exp_cc += 4;
        checks++;
        if (state !== 3'd0 || instr_cnt !== 32'(exp_ic) || cycle_cnt !== 32'(exp_cc)) begin
            errors++; $display("FAIL addu_cnt got st%0d %0d/%0d exp st0 %0d/%0d",
                               state, instr_cnt, cycle_cnt, exp_ic, exp_cc);
        end
    endtask

    task automatic test_lw_stall();
        logic [19:0] e [8];
        e[0] = fetch_v;
        e[1] = ev(3'd1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 2'd0, 2'd0, 0);
        e[2] = ev(3'd2, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 1, 2'd0, 2'd0, 0);
        for (int i = 3; i < 7; i++) e[i] = ev(3'd3, 0, 0, 0, 0, 1, 2'd0, 3'd0, 0, 0, 2'd0, 2'd0, 0);
        e[7] = ev(3'd4, 0, 0, 1, 0, 0, 2'd0, 3'd0, 0, 0, 2'd0, 2'd1, 0);
        opcode = 6'b100011; funct = 6'b000000;
        for (int i = 0; i < 8; i++) begin
            dm_ready = (i >= 6);
            #1;
            checks++;
            if (outs !== e[i]) begin
                errors++; $display("FAIL lw_c%0d got %h exp %h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
        exp_ic += 1; exp_cc += 8;
        checks++;
        if (state !== 3'd0 || instr_cnt !== 32'(exp_ic) || cycle_cnt !== 32'(exp_cc)) begin
            errors++; $display("FAIL lw_cnt got st%0d %0d/%0d exp st0 %0d/%0d",
                               state, instr_cnt, cycle_cnt, exp_ic, exp_cc);
        end
    endtask

    task automatic test_beq();
        logic [19:0] e [3];
        for (int z = 1; z >= 0; z--) begin
            e[0] = fetch_v;
            e[1] = ev(3'd1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 2'd0, 2'd0, 0);
            e[2] = (z == 1) ? ev(3'd2, 1, 0, 0, 0, 0, 2'd1, 3'd1, 0, 1, 2'd0, 2'd0, 0)
                            : ev(3'd2, 0, 0, 0, 0, 0, 2'd0, 3'd1, 0, 1, 2'd0, 2'd0, 0);
            opcode = 6'b000100; funct = 6'b000000; zero = z[0];
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if (outs !== e[i]) begin
                    errors++; $display("FAIL beq_z%0d_c%0d got %h exp %h", z, i, outs, e[i]);
                end
                @(posedge clk); #1;
            end
            exp_ic += 1; exp_cc += 3;
            checks++;
            if (state !== 3'd0 || instr_cnt !== 32'(exp_ic) || cycle_cnt !== 32'(exp_cc)) begin
                errors++; $display("FAIL beq_z%0d_cnt got st%0d %0d/%0d exp st0 %0d/%0d",
                                   z, state, instr_cnt, cycle_cnt, exp_ic, exp_cc);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        logic [19:0] e [2];
        e[0] = fetch_v;
        e[1] = ev(3'd1, 1, 0, 1, 0, 0, 2'd2, 3'd0, 0, 0, 2'd2, 2'd2, 0);
        opcode = 6'b000011; funct = 6'b000000;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (outs !== e[i]) begin
                errors++; $display("FAIL jal_c%0d got %h exp %h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
        exp_ic += 1; exp_cc += 2;
        checks++;
        if (state !== 3'd0 || instr_cnt !== 32'(exp_ic) || cycle_cnt !== 32'(exp_cc)) begin
            errors++; $display("FAIL jal_cnt got st%0d %0d/%0d exp st0 %0d/%0d",
                               state, instr_cnt, cycle_cnt, exp_ic, exp_cc);
        end
    endtask

    task automatic test_illegal();
        logic [5:0]  ops [2];
        logic [5:0]  fns [2];
        logic [19:0] e [3];
        ops[0] = 6'b111111; fns[0] = 6'b100001;
        ops[1] = 6'b000000; fns[1] = 6'b000000;
        e[0] = fetch_v;
        e[1] = ev(3'd1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 2'd0, 2'd0, 1);
        e[2] = fetch_v;
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k]; funct = fns[k];
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if (outs !== e[i]) begin
                    errors++; $display("FAIL illegal%0d_c%0d got %h exp %h", k, i, outs, e[i]);
                end
                if (i < 2) begin
                    @(posedge clk); #1;
                end
            end
            exp_ic += 1; exp_cc += 2;
            checks++;
            if (instr_cnt !== 32'(exp_ic) || cycle_cnt !== 32'(exp_cc)) begin
                errors++; $display("FAIL illegal%0d_cnt got %0d/%0d exp %0d/%0d",
                                   k, instr_cnt, cycle_cnt, exp_ic, exp_cc);
            end
        end
    endtask

    task automatic test_misc();
        logic [5:0]  ops [6];
        logic [5:0]  fns [6];
        int          cyc [6];
        int          kix [6];
        logic [19:0] kv  [6];
        int          n;
        ops[0] = 6'b000010; fns[0] = 6'd0;       cyc[0] = 2; kix[0] = 1;
        kv[0]  = ev(3'd1, 1, 0, 0, 0, 0, 2'd2, 3'd0, 0, 0, 2'd0, 2'd0, 0);
        ops[1] = 6'b000000; fns[1] = 6'b001000; cyc[1] = 2; kix[1] = 1;
        kv[1]  = ev(3'd1, 1, 0, 0, 0, 0, 2'd3, 3'd0, 0, 0, 2'd0, 2'd0, 0);
        ops[2] = 6'b001101; fns[2] = 6'd0;       cyc[2] = 4; kix[2] = 2;
        kv[2]  = ev(3'd2, 0, 0, 0, 0, 0, 2'd0, 3'd2, 1, 0, 2'd0, 2'd0, 0);
        ops[3] = 6'b001111; fns[3] = 6'd0;       cyc[3] = 4; kix[3] = 3;
        kv[3]  = ev(3'd4, 0, 0, 1, 0, 0, 2'd0, 3'd0, 0, 0, 2'd0, 2'd0, 0);
        ops[4] = 6'b000000; fns[4] = 6'b100011; cyc[4] = 4; kix[4] = 2;
        kv[4]  = ev(3'd2, 0, 0, 0, 0, 0, 2'd0, 3'd1, 0, 0, 2'd0, 2'd0, 0);
        ops[5] = 6'b101011; fns[5] = 6'd0;       cyc[5] = 4; kix[5] = 3;
        kv[5]  = ev(3'd3, 0, 0, 0, 1, 1, 2'd0, 3'd0, 0, 0, 2'd0, 2'd0, 0);
        dm_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            opcode = ops[k]; funct = fns[k];
            #1;
            n = 0;
            do begin
                if (n == kix[k]) begin
                    checks++;
                    if (outs !== kv[k]) begin
                        errors++; $display("FAIL misc%0d_key got %h exp %h", k, outs, kv[k]);
                    end
                end
                @(posedge clk); #1;
                n++;
            end while (state !== 3'd0 && n < 20);
            exp_ic += 1; exp_cc += cyc[k];
            checks++;
            if (n != cyc[k] || instr_cnt !== 32'(exp_ic) || cycle_cnt !== 32'(exp_cc)) begin
                errors++; $display("FAIL misc%0d_len got %0d cyc %0d/%0d exp %0d cyc %0d/%0d",
                                   k, n, instr_cnt, cycle_cnt, cyc[k], exp_ic, exp_cc);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] e [4];
        opcode = 6'b101011; funct = 6'd0; dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        #1;
        checks++;
        if (outs !== ev(3'd3, 0, 0, 0, 1, 1, 2'd0, 3'd0, 0, 0, 2'd0, 2'd0, 0)) begin
            errors++; $display("FAIL rmid_mem got %h", outs);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (outs !== 20'd0 || instr_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
            errors++; $display("FAIL rmid_reset got %h %0d/%0d exp 00000 0/0",
                               outs, instr_cnt, cycle_cnt);
        end
        exp_ic = 0; exp_cc = 0;
        reset = 1'b1; dm_ready = 1'b1;
        #1;
        e[0] = fetch_v;
        e[1] = ev(3'd1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 2'd0, 2'd0, 0);
        e[2] = ev(3'd2, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 1, 2'd0, 2'd0, 0);
        e[3] = ev(3'd3, 0, 0, 0, 1, 1, 2'd0, 3'd0, 0, 0, 2'd0, 2'd0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (outs !== e[i]) begin
                errors++; $display("FAIL rmid_sw_c%0d got %h exp %h", i, outs, e[i]);
            end
            @(posedge clk); #1;
        end
        exp_ic += 1; exp_cc += 4;
        checks++;
        if (state !== 3'd0 || instr_cnt !== 32'(exp_ic) || cycle_cnt !== 32'(exp_cc)) begin
            errors++; $display("FAIL rmid_cnt got st%0d %0d/%0d exp st0 %0d/%0d",
                               state, instr_cnt, cycle_cnt, exp_ic, exp_cc);
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw_stall();
        test_beq();
        test_jal();
        test_illegal();
        test_misc();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS core. It sequences the shared datapath (PC, IR, GRF, ALU, DM) through the Fetch/Decode/Execute/Memory/Writeback phases, one instruction at a time.
- It decodes the IR opcode and funct fields and drives every enable and select in the datapath.
- It stalls on the data-memory ready handshake and keeps retired-instruction and cycle counters for the bench.

Parameters:
- CNT_W, 32, width of the instr_cnt and cycle_cnt counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  6  IR[31:26]; valid from DECODE onward.
- funct  input  6  IR[5:0].
- zero  input  1  ALU equality flag, used by beq in EXEC.
- dm_ready  input  1  data-memory ready; sampled only in the MEM state.
- pc_we  output  1  PC write enable.
- ir_we  output  1  IR write enable.
- grf_we  output  1  register-file write enable.
- dm_we  output  1  data-memory write strobe.
- dm_req  output  1  data-memory access request.
- npc_sel  output  2  next-PC select: 0 = PC+4, 1 = branch target, 2 = j/jal target, 3 = rs.
- alu_op  output  3  ALU operation: 0 = add, 1 = sub, 2 = or, 3 = lui shift.
- alu_b_sel  output  1  ALU B operand: 0 = rt, 1 = extended immediate.
- ext_op  output  1  extender mode: 0 = zero-extend, 1 = sign-extend.
- a3_sel  output  2  write-register select: 0 = rt, 1 = rd, 2 = $31.
- wd_sel  output  2  write-data select: 0 = ALU, 1 = DM, 2 = PC+4.
- state  output  3  current FSM state.
- illegal  output  1  one-cycle pulse on an unknown opcode or funct.
- instr_cnt  output  CNT_W  count of retired instructions.
- cycle_cnt  output  CNT_W  cycles since reset release.

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4. Encodings 5–7 go to FETCH on the next edge.
- Reset (reset = 0, asynchronous): state = FETCH, instr_cnt = 0, cycle_cnt = 0. While reset is low every enable output (pc_we, ir_we, grf_we, dm_we, dm_req, illegal) is 0 regardless of state.
- A reset asserted mid-instruction aborts it. Any partly completed instruction is not counted.
- Outputs are combinational from state, opcode and funct. Selects with no meaning in the current state are 0.
- FETCH: ir_we = 1, pc_we = 1, npc_sel = 0. Next state is DECODE.
- DECODE:
  - j: pc_we = 1, npc_sel = 2. Instruction retires; next state FETCH.
  - jal: pc_we = 1, npc_sel = 2, grf_we = 1, a3_sel = 2, wd_sel = 2. Retires; next state FETCH.
  - jr (R-type, funct 001000): pc_we = 1, npc_sel = 3. Retires; next state FETCH.
  - Unknown opcode, or R-type with a funct other than 100001/100011/001000: illegal = 1. Treated as a nop and retires; next state FETCH.
  - All other instructions: next state EXEC.
- EXEC:
  - addu: alu_op = 0, alu_b_sel = 0. Next state WB.
  - subu: alu_op = 1, alu_b_sel = 0. Next state WB.
  - ori: alu_op = 2, alu_b_sel = 1, ext_op = 0. Next state WB.
  - lui: alu_op = 3, alu_b_sel = 1. Next state WB.
  - lw / sw: alu_op = 0, alu_b_sel = 1, ext_op = 1. Next state MEM.
  - beq: alu_op = 1, alu_b_sel = 0, ext_op = 1. If zero = 1 then pc_we = 1 and npc_sel = 1. Retires; next state FETCH.
- MEM: dm_req = 1; for sw, dm_we = 1 as well. Stays in MEM while dm_ready = 0.
  - dm_ready = 1 on sw: retires; next state FETCH.
  - dm_ready = 1 on lw: next state WB.
  - dm_ready high on the first MEM cycle gives zero wait states.
- WB: grf_we = 1.
  - a3_sel = 1 for R-type, 0 for ori/lui/lw.
  - wd_sel = 1 for lw, 0 otherwise.
  - Retires; next state FETCH.
- Cycle counts with no memory stall: j/jal/jr/illegal = 2, beq = 3, addu/subu/ori/lui/sw = 4, lw = 5. Each dm_ready = 0 cycle adds one.
- instr_cnt increments by 1 on every edge where an instruction retires.
- cycle_cnt increments on every edge while out of reset.
- Both counters wrap modulo 2^CNT_W with no flag.
- The opcode and funct inputs are ignored in FETCH.

Test Plan:
- Release reset, then addu (opcode 0, funct 100001) → states 0,1,2,4; grf_we = 1 only in WB with a3_sel = 1; after 4 cycles instr_cnt = 1 and cycle_cnt = 4.
- lw (100011) with dm_ready held low for 3 MEM cycles → MEM occupies 4 cycles, dm_we = 0, wd_sel = 1 in WB; the instruction takes 8 cycles total.
- beq (000100) with zero = 1, then with zero = 0 → pc_we = 1 and npc_sel = 1 in EXEC only for zero = 1; each takes 3 cycles and instr_cnt increments.
- jal (000011) → grf_we = 1, a3_sel = 2, wd_sel = 2, npc_sel = 2, all in DECODE; next state FETCH; 2 cycles.
- Opcode 111111, then R-type with funct 000000 → illegal pulses for one cycle in DECODE each time; no grf_we or dm_we; instr_cnt increments.
- Drive reset low in the MEM state of an sw → state = 0 immediately (asynchronous), dm_we = 0, both counters = 0; execution resumes in FETCH after release.
